bbcd_seq_ctrl: RTL and testbench

Sequential binary-to-BCD converter (shift-add-3 / double dabble) for the calculator result path. It takes a 16-bit unsigned binary result and produces five packed BCD digits for the display stage. The block holds the datapath and control FSM. Iteration counting is delegated to the external 16-step down-counter (CONTADOR_BBCD), which this block drives through LD/DEC and monitors through Z.

---
 rtl/bbcd_seq_ctrl.sv | 98 +++++++++
 tb/tb_bbcd_seq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bbcd_seq_ctrl.sv
// Sequential 16-bit binary to 5-digit packed BCD converter (shift-add-3).
// Iterations are counted by an external down-counter driven via LD/DEC and sampled via Z.
module bbcd_seq_ctrl (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [15:0] BIN,
    output logic        LD,
    output logic        DEC,
    input  logic        Z,
    output logic [19:0] BCD,
    output logic        DONE,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADJ   = 3'd2,
        SHIFT = 3'd3,
        CHECK = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] bin_sr_reg, bin_sr_next;
    logic [19:0] acc_reg, acc_next;
    logic [19:0] bcd_reg, bcd_next;
    logic        done_reg, done_next;
    logic [19:0] acc_adj;

    // Each digit is corrected independently; no carry crosses digit boundaries.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_digit_adj
            assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                        (acc_reg[gi*4 +: 4] + 4'd3) :
                                        acc_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg  <= IDLE;
            bin_sr_reg <= '0;
            acc_reg    <= '0;
            bcd_reg    <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            bin_sr_reg <= bin_sr_next;
            acc_reg    <= acc_next;
            bcd_reg    <= bcd_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        bin_sr_next = bin_sr_reg;
        acc_next    = acc_reg;
        bcd_next    = bcd_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (START) begin
                    bin_sr_next = BIN;
                    acc_next    = '0;
                    state_next  = LOAD;
                end
            end
            LOAD: state_next = ADJ;
            ADJ: begin
                if (Z) begin
                    bcd_next   = acc_reg;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    acc_next   = acc_adj;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                acc_next    = {acc_reg[18:0], bin_sr_reg[15]};
                bin_sr_next = {bin_sr_reg[14:0], 1'b0};
                state_next  = CHECK;
            end
            // Gives the counter one edge to raise Z before it is sampled in ADJ.
            CHECK: state_next = ADJ;
            default: state_next = IDLE;
        endcase
    end

    assign LD   = (state_reg == LOAD);
    assign DEC  = (state_reg == SHIFT);
    assign BUSY = (state_reg != IDLE);
    assign BCD  = bcd_reg;
    assign DONE = done_reg;

endmodule

// File: tb/tb_bbcd_seq_ctrl.sv
// Scoreboard bench for bbcd_seq_ctrl with a behavioural 16-step down-counter attached.
module tb_bbcd_seq_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [15:0] BIN = '0;
    logic        LD, DEC, DONE, BUSY;
    logic        Z = 1'b0;
    logic [19:0] BCD;

    bbcd_seq_ctrl dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .BIN   (BIN),
        .LD    (LD),
        .DEC   (DEC),
        .Z     (Z),
        .BCD   (BCD),
        .DONE  (DONE),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    // Counter model: LD loads 16 and clears Z; Z rises one edge after count reaches 0.
    logic [4:0] count = 5'd0;
    always @(posedge CLK) begin
        if (LD) begin
            count <= 5'd16;
            Z     <= 1'b0;
        end else begin
            if (DEC && count != 0) count <= count - 5'd1;
            if (count == 0) Z <= 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [19:0] bcd;
        int          cyc;
        logic [15:0] bin;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int ld_cnt = 0;
    int dec_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops expected results whenever DONE is presented.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (LD) ld_cnt++;
            if (DEC) dec_cnt++;
            if (DONE) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got BCD=%05h, expected no DONE", BCD);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("txn BIN=%0d BCD=%05h cycle=%0d", e.bin, BCD, cyc);
                    check("bcd_value", {12'd0, BCD}, {12'd0, e.bcd});
                    check("done_latency", cyc, e.cyc);
                    check("ld_cycles", ld_cnt, 1);
                    check("dec_cycles", dec_cnt, 16);
                end
                ld_cnt = 0;
                dec_cnt = 0;
            end else if (!BUSY) begin
                ld_cnt = 0;
                dec_cnt = 0;
            end
        end
    end

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no DONE, expected DONE within 60 cycles");
        end
    endtask

    // Issue START; with hold set, START stays high and BIN changes through the busy window.
    task automatic convert(input logic [15:0] b, input logic [19:0] e, input bit hold);
        START = 1'b1;
        BIN   = b;
        @(posedge CLK);
        #1;
        q.push_back('{bcd: e, cyc: cyc + 50, bin: b});
        check("busy_after_accept", {31'd0, BUSY}, 32'd1);
        if (hold) begin
            BIN = 16'd1;
            repeat (48) @(posedge CLK);
            #1;
        end
        START = 1'b0;
        BIN   = 16'hA5A5;
        wait_done();
    endtask

    task automatic check_hold(input logic [19:0] e);
        repeat (3) @(posedge CLK);
        #1;
        check("bcd_hold", {12'd0, BCD}, {12'd0, e});
        check("busy_idle", {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("rst_bcd", {12'd0, BCD}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_ld", {31'd0, LD}, 32'd0);
        check("rst_dec", {31'd0, DEC}, 32'd0);
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        convert(16'd0, 20'h00000, 0);
        check_hold(20'h00000);
        convert(16'd65535, 20'h65535, 0);
        check_hold(20'h65535);
        convert(16'd12345, 20'h12345, 0);
        check_hold(20'h12345);
        convert(16'd10, 20'h00010, 0);
        check_hold(20'h00010);
        convert(16'd999, 20'h00999, 1);
        repeat (60) @(posedge CLK);
        #1;
        check("bcd_after_hold", {12'd0, BCD}, 32'h00999);

        // Back-to-back: second START issued in the DONE cycle of the first.
        convert(16'd7, 20'h00007, 0);
        START = 1'b1;
        BIN   = 16'd42;
        @(posedge CLK);
        #1;
        q.push_back('{bcd: 20'h00042, cyc: cyc + 50, bin: 16'd42});
        START = 1'b0;
        wait_done();
        check_hold(20'h00042);

        // Abort during the 8th SHIFT cycle with an asynchronous reset.
        START = 1'b1;
        BIN   = 16'd321;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (23) @(posedge CLK);
        #1;
        check("abort_in_shift", {31'd0, DEC}, 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_bcd", {12'd0, BCD}, 32'd0);
        check("async_busy", {31'd0, BUSY}, 32'd0);
        check("async_dec", {31'd0, DEC}, 32'd0);
        check("async_ld", {31'd0, LD}, 32'd0);
        check("async_done", {31'd0, DONE}, 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (60) @(posedge CLK);
        #1;
        check("idle_after_abort", {31'd0, BUSY}, 32'd0);
        convert(16'd500, 20'h00500, 0);
        check_hold(20'h00500);

        check("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
